// File: rtl/servo_motion_sequencer_if.sv
// Command/status bundle between the one-shot debouncers, the PWM period counter
// and the servo motion sequencer.
interface servo_motion_sequencer_if;
   logic        period_tick;
   logic        inc_req;
   logic        dec_req;
   logic        sweep_req;
   logic        home_req;
   logic [31:0] dc;
   logic [2:0]  state;
   logic        at_min;
   logic        at_max;
   logic        busy;

   modport master (
      output period_tick, inc_req, dec_req, sweep_req, home_req,
      input  dc, state, at_min, at_max, busy
   );

   modport slave (
      input  period_tick, inc_req, dec_req, sweep_req, home_req,
      output dc, state, at_min, at_max, busy
   );
endinterface

// File: rtl/servo_motion_sequencer.sv
// Owns the servo PWM duty count: manual step commands, homing and an autonomous
// back-and-forth sweep, with every duty change committed on a PWM period tick.
module servo_motion_sequencer #(
   parameter logic [31:0] MIN_DC        = 32'd50_000,
   parameter logic [31:0] MAX_DC        = 32'd100_000,
   parameter logic [31:0] HOME_DC       = 32'd75_000,
   parameter logic [31:0] STEP          = 32'd2_500,
   parameter int unsigned STEP_PERIODS  = 2,
   parameter int unsigned DWELL_PERIODS = 10
) (
   input  logic                      clk_div,
   input  logic                      one_shot_rst,
   servo_motion_sequencer_if.slave   ctl
);

   typedef enum logic [2:0] {
      MANUAL   = 3'd0,
      SWEEP_UP = 3'd1,
      DWELL_HI = 3'd2,
      SWEEP_DN = 3'd3,
      DWELL_LO = 3'd4,
      HOME     = 3'd5
   } state_t;

   localparam logic [15:0] STEP_LAST  = 16'(STEP_PERIODS - 1);
   localparam logic [15:0] DWELL_LAST = 16'(DWELL_PERIODS - 1);

   state_t      state_q, state_d;
   logic [31:0] dc_q, dc_d;
   logic [31:0] target_q, target_d;
   logic [15:0] step_cnt_q, step_cnt_d;
   logic [15:0] dwell_cnt_q, dwell_cnt_d;
   logic        at_min_q, at_max_q;

   // Saturating neighbours; compare first so the subtraction can never wrap.
   logic [31:0] target_up, target_dn, dc_up, dc_dn;
   assign target_up = (target_q >= MAX_DC - STEP) ? MAX_DC : target_q + STEP;
   assign target_dn = (target_q <= MIN_DC + STEP) ? MIN_DC : target_q - STEP;
   assign dc_up     = (dc_q >= MAX_DC - STEP) ? MAX_DC : dc_q + STEP;
   assign dc_dn     = (dc_q <= MIN_DC + STEP) ? MIN_DC : dc_q - STEP;

   always_ff @(posedge clk_div or posedge one_shot_rst) begin
      if (one_shot_rst) begin
         state_q     <= MANUAL;
         dc_q        <= HOME_DC;
         target_q    <= HOME_DC;
         step_cnt_q  <= '0;
         dwell_cnt_q <= '0;
         at_min_q    <= 1'b0;
         at_max_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         dc_q        <= dc_d;
         target_q    <= target_d;
         step_cnt_q  <= step_cnt_d;
         dwell_cnt_q <= dwell_cnt_d;
         at_min_q    <= (dc_d == MIN_DC);
         at_max_q    <= (dc_d == MAX_DC);
      end
   end

   always_comb begin
      state_d     = state_q;
      dc_d        = dc_q;
      target_d    = target_q;
      step_cnt_d  = step_cnt_q;
      dwell_cnt_d = dwell_cnt_q;

      if (ctl.home_req) begin
         target_d = HOME_DC;
         state_d  = HOME;
         if (ctl.period_tick) dc_d = target_q;
      end else if (ctl.sweep_req && state_q != HOME) begin
         if (state_q == MANUAL) begin
            state_d    = (dc_q == MAX_DC) ? SWEEP_DN : SWEEP_UP;
            step_cnt_d = '0;
         end else begin
            state_d = MANUAL;
         end
         // Outside MANUAL target already tracks dc, so this only drops a pending manual edit.
         target_d = dc_q;
      end else begin
         case (state_q)
            MANUAL: begin
               if (ctl.inc_req && !ctl.dec_req) target_d = target_up;
               if (ctl.dec_req && !ctl.inc_req) target_d = target_dn;
               if (ctl.period_tick) dc_d = target_q;
            end
            SWEEP_UP: if (ctl.period_tick) begin
               if (step_cnt_q == STEP_LAST) begin
                  dc_d       = dc_up;
                  target_d   = dc_up;
                  step_cnt_d = '0;
                  if (dc_up == MAX_DC) begin
                     state_d     = DWELL_HI;
                     dwell_cnt_d = '0;
                  end
               end else begin
                  step_cnt_d = step_cnt_q + 16'd1;
               end
            end
            SWEEP_DN: if (ctl.period_tick) begin
               if (step_cnt_q == STEP_LAST) begin
                  dc_d       = dc_dn;
                  target_d   = dc_dn;
                  step_cnt_d = '0;
                  if (dc_dn == MIN_DC) begin
                     state_d     = DWELL_LO;
                     dwell_cnt_d = '0;
                  end
               end else begin
                  step_cnt_d = step_cnt_q + 16'd1;
               end
            end
            DWELL_HI, DWELL_LO: if (ctl.period_tick) begin
               if (dwell_cnt_q == DWELL_LAST) begin
                  state_d    = (state_q == DWELL_HI) ? SWEEP_DN : SWEEP_UP;
                  step_cnt_d = '0;
               end else begin
                  dwell_cnt_d = dwell_cnt_q + 16'd1;
               end
            end
            HOME: if (ctl.period_tick) begin
               dc_d    = HOME_DC;
               state_d = MANUAL;
            end
            default: begin
               state_d  = MANUAL;
               target_d = dc_q;
            end
         endcase
      end
   end

   assign ctl.dc     = dc_q;
   assign ctl.state  = state_q;
   assign ctl.at_min = at_min_q;
   assign ctl.at_max = at_max_q;
   assign ctl.busy   = (state_q != MANUAL) || (target_q != dc_q);

endmodule
